// File: rtl/ram_copy_engine.sv
// Block copy / block fill engine that drives the shared RAM data port.
// Copy alternates RD/WR per word; fill streams one write per cycle.
module ram_copy_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mode,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  input  logic [DATA_WIDTH-1:0] fill_data,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  words_done,
  output logic                  wEn,
  output logic [ADDR_WIDTH-1:0] d_address,
  output logic [DATA_WIDTH-1:0] d_write_data,
  input  logic [DATA_WIDTH-1:0] d_read_data
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] src_q, src_nxt, src_inc;
  logic [ADDR_WIDTH-1:0] dst_q, dst_nxt, dst_inc;
  logic [LEN_WIDTH-1:0]  len_q, len_nxt;
  logic                  mode_q, mode_nxt;
  logic [LEN_WIDTH-1:0]  wd_nxt, wd_inc;
  logic                  wen_nxt;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [DATA_WIDTH-1:0] wdata_nxt;

  // Byte pointers step one word and wrap naturally at the address width.
  assign src_inc = src_q + ADDR_WIDTH'(4);
  assign dst_inc = dst_q + ADDR_WIDTH'(4);
  assign wd_inc  = words_done + LEN_WIDTH'(1);

  assign busy = (state == RD) || (state == WR);
  assign done = (state == DONE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    src_nxt   = src_q;
    dst_nxt   = dst_q;
    len_nxt   = len_q;
    mode_nxt  = mode_q;
    wd_nxt    = words_done;
    wen_nxt   = wEn;
    addr_nxt  = d_address;
    wdata_nxt = d_write_data;
    case (state)
      IDLE: begin
        if (start) begin
          src_nxt  = src_addr;
          dst_nxt  = dst_addr;
          len_nxt  = length;
          mode_nxt = mode;
          wd_nxt   = '0;
          if (length == '0) begin
            state_nxt = DONE;
          end else if (!mode) begin
            state_nxt = RD;
            addr_nxt  = src_addr;
            wen_nxt   = 1'b0;
          end else begin
            state_nxt = WR;
            addr_nxt  = dst_addr;
            wdata_nxt = fill_data;
            wen_nxt   = 1'b1;
          end
        end
      end
      RD: begin
        if (abort) begin
          state_nxt = IDLE;
          wen_nxt   = 1'b0;
        end else begin
          state_nxt = WR;
          wdata_nxt = d_read_data;
          addr_nxt  = dst_q;
          wen_nxt   = 1'b1;
        end
      end
      WR: begin
        // The presented write commits at this edge, aborted or not, so it is always counted.
        wd_nxt  = wd_inc;
        src_nxt = src_inc;
        dst_nxt = dst_inc;
        if (abort) begin
          state_nxt = IDLE;
          wen_nxt   = 1'b0;
        end else if (wd_inc == len_q) begin
          state_nxt = DONE;
          wen_nxt   = 1'b0;
        end else if (!mode_q) begin
          state_nxt = RD;
          addr_nxt  = src_inc;
          wen_nxt   = 1'b0;
        end else begin
          addr_nxt = dst_inc;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wEn          <= 1'b0;
      d_address    <= '0;
      d_write_data <= '0;
      words_done   <= '0;
    end else begin
      wEn          <= wen_nxt;
      d_address    <= addr_nxt;
      d_write_data <= wdata_nxt;
      words_done   <= wd_nxt;
    end
  end

  // Transfer context is only meaningful after an accepted start, so it carries no reset.
  always_ff @(posedge clock) begin
    src_q  <= src_nxt;
    dst_q  <= dst_nxt;
    len_q  <= len_nxt;
    mode_q <= mode_nxt;
  end

endmodule

// File: tb/tb_ram_copy_engine.sv
// Bench for ram_copy_engine: a word RAM on the data port, a reference memory
// updated by plain per-word copy/fill rules, table vectors, random transfers and corner sequences.
module tb_ram_copy_engine;

  localparam int MEM_WORDS = 16384;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] src_addr = '0;
  logic [15:0] dst_addr = '0;
  logic [15:0] length = '0;
  logic [31:0] fill_data = '0;
  logic        abort = 1'b0;
  logic        busy, done, wEn;
  logic [15:0] words_done, d_address;
  logic [31:0] d_write_data, d_read_data;
  logic        seed_req = 1'b0;

  logic [31:0] mem     [0:MEM_WORDS-1];
  logic [31:0] ref_mem [0:MEM_WORDS-1];

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit          m;
    logic [15:0] src;
    logic [15:0] dst;
    int          len;
    logic [31:0] fill;
    int          poke;
    int          exp_busy;
    int          exp_done_at;
    int          exp_wen;
    int          exp_words;
  } vec_t;

  ram_copy_engine #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .LEN_WIDTH(16)) dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length), .fill_data(fill_data),
    .abort(abort), .busy(busy), .done(done), .words_done(words_done), .wEn(wEn),
    .d_address(d_address), .d_write_data(d_write_data), .d_read_data(d_read_data)
  );

  always #5 clock = ~clock;

  assign d_read_data = mem[d_address[15:2]];

  always @(posedge clock) begin
    if (seed_req) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= 32'(i) * 32'h9E3779B9 + 32'h12345678;
    end else if (wEn) begin
      mem[d_address[15:2]] <= d_write_data;
    end
  end

  function automatic void model_xfer(input bit m, input logic [15:0] s, input logic [15:0] d,
                                     input int n, input logic [31:0] f);
    logic [15:0] sa, da;
    for (int i = 0; i < n; i++) begin
      sa = s + 16'(4 * i);
      da = d + 16'(4 * i);
      ref_mem[da[15:2]] = m ? f : ref_mem[sa[15:2]];
    end
  endfunction

  function automatic int mem_mismatches();
    int cnt = 0;
    for (int i = 0; i < MEM_WORDS; i++) if (mem[i] !== ref_mem[i]) cnt++;
    return cnt;
  endfunction

  task automatic check(input string tag, input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h, expected %0h", tag, name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    int busy_cnt = 0, done_cnt = 0, done_at = -1, wen_cnt = 0;
    @(negedge clock);
    mode = v.m; src_addr = v.src; dst_addr = v.dst; length = 16'(v.len);
    fill_data = v.fill; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int c = 0; c < 2 * v.len + 6; c++) begin
      if (busy) busy_cnt++;
      if (wEn) wen_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      if (c == v.poke) begin
        start = 1'b1; mode = ~v.m; src_addr = 16'h0500; dst_addr = 16'h0600; length = 16'd7;
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
    end
    start = 1'b0;
    model_xfer(v.m, v.src, v.dst, v.len, v.fill);
    check(tag, "busy_cycles", 64'(busy_cnt), 64'(v.exp_busy));
    check(tag, "done_pulses", 64'(done_cnt), 64'd1);
    check(tag, "done_cycle", 64'(done_at), 64'(v.exp_done_at));
    check(tag, "wen_cycles", 64'(wen_cnt), 64'(v.exp_wen));
    check(tag, "words_done", 64'(words_done), 64'(v.exp_words));
    check(tag, "mem_diffs", 64'(mem_mismatches()), 64'd0);
  endtask

  vec_t vecs[6];
  vec_t rv;

  initial begin
    int dc;
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = 32'(i) * 32'h9E3779B9 + 32'h12345678;

    vecs[0] = '{0, 16'h0010, 16'h0040, 3, 32'h0,        -1, 6, 6, 3, 3};
    vecs[1] = '{1, 16'h0000, 16'h0020, 4, 32'hDEADBEEF, -1, 4, 4, 4, 4};
    vecs[2] = '{0, 16'h0010, 16'h0060, 0, 32'h0,        -1, 0, 0, 0, 0};
    vecs[3] = '{1, 16'h0000, 16'hFFF8, 3, 32'hCAFEF00D,  1, 3, 3, 3, 3};
    vecs[4] = '{0, 16'h0080, 16'h0084, 4, 32'h0,        -1, 8, 8, 4, 4};
    vecs[5] = '{0, 16'h00A0, 16'h00C0, 1, 32'h0,        -1, 2, 2, 1, 1};

    seed_req = 1'b1;
    repeat (2) @(negedge clock);
    seed_req = 1'b0;
    check("reset", "busy", 64'(busy), 64'd0);
    check("reset", "done", 64'(done), 64'd0);
    check("reset", "wEn", 64'(wEn), 64'd0);
    check("reset", "d_address", 64'(d_address), 64'd0);
    check("reset", "d_write_data", 64'(d_write_data), 64'd0);
    check("reset", "words_done", 64'(words_done), 64'd0);
    reset = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 6; i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Abort during the second write of a 4-word copy.
    @(negedge clock);
    mode = 1'b0; src_addr = 16'h0300; dst_addr = 16'h0380; length = 16'd4; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    check("abort", "wen_before", 64'(wEn), 64'd1);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check("abort", "busy", 64'(busy), 64'd0);
    check("abort", "wEn", 64'(wEn), 64'd0);
    check("abort", "words_done", 64'(words_done), 64'd2);
    dc = 0;
    for (int c = 0; c < 5; c++) begin
      if (done) dc++;
      @(negedge clock);
    end
    check("abort", "done_pulses", 64'(dc), 64'd0);
    model_xfer(1'b0, 16'h0300, 16'h0380, 2, 32'h0);
    check("abort", "mem_diffs", 64'(mem_mismatches()), 64'd0);

    // Reset mid-copy while the second write is being presented.
    @(negedge clock);
    mode = 1'b0; src_addr = 16'h0100; dst_addr = 16'h0200; length = 16'd4; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    #1 reset = 1'b0;
    #1;
    check("rst_mid", "wEn", 64'(wEn), 64'd0);
    check("rst_mid", "busy", 64'(busy), 64'd0);
    check("rst_mid", "words_done", 64'(words_done), 64'd0);
    model_xfer(1'b0, 16'h0100, 16'h0200, 1, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    check("rst_mid", "mem_diffs", 64'(mem_mismatches()), 64'd0);
    rv = '{0, 16'h0100, 16'h0240, 4, 32'h0, -1, 8, 8, 4, 4};
    apply(rv, "after_rst");

    for (int i = 0; i < 20; i++) begin
      rv.m    = 1'($urandom_range(0, 1));
      rv.src  = 16'($urandom_range(0, 255)) << 2;
      rv.dst  = 16'($urandom_range(0, 255)) << 2;
      rv.len  = int'($urandom_range(0, 8));
      rv.fill = $urandom;
      rv.poke = -1;
      rv.exp_busy    = rv.m ? rv.len : 2 * rv.len;
      rv.exp_done_at = rv.exp_busy;
      rv.exp_wen     = rv.len;
      rv.exp_words   = rv.len;
      apply(rv, $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
